// File: rtl/voice_mixer_seq.sv
// Time-multiplexed oscillator mixer: snapshot on strobe, accumulate one channel per clock,
// then master volume, n/(n+2) loudness normalisation and saturation through a short pipeline.
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 4
`endif
`ifndef VOLUME_FIXED_POINT
`define VOLUME_FIXED_POINT 16
`endif

module voice_mixer_seq #(
    parameter int WIDTH      = 24,
    parameter int N_CHANNELS = `N_OSCILLATORS,
    parameter int GAIN_WIDTH = 16,
    parameter int VOL_FRAC   = `VOLUME_FIXED_POINT,
    parameter int NORM_FRAC  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_strobe,
    input  logic signed [WIDTH-1:0]      waves [N_CHANNELS],
    input  logic        [GAIN_WIDTH-1:0] gains [N_CHANNELS],
    input  logic        [N_CHANNELS-1:0] enable,
    input  logic signed [31:0]           master_volume,
    output logic signed [WIDTH-1:0]      out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         clip,
    output logic                         overrun
);

    localparam int IDX_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int CNT_W = $clog2(N_CHANNELS + 1);
    localparam int ACC_W = WIDTH + GAIN_WIDTH + 1 + $clog2(N_CHANNELS);
    localparam int S_W   = ACC_W + 32;
    localparam int Y_W   = S_W + NORM_FRAC + 1;

    typedef enum logic [2:0] {IDLE, ACCUM, SCALE, NORM, SAT} state_t;

    state_t state, state_next;

    logic signed [WIDTH-1:0]      wave_q [N_CHANNELS];
    logic        [GAIN_WIDTH-1:0] gain_q [N_CHANNELS];
    logic        [N_CHANNELS-1:0] en_q;
    logic signed [31:0]           mv_q;
    logic signed [ACC_W-1:0]      acc;
    logic        [CNT_W-1:0]      n_q;
    logic        [IDX_W-1:0]      idx;
    logic signed [S_W-1:0]        s_q;
    logic signed [Y_W-1:0]        y_q;

    // Loudness table n/(n+2) in Q0.NORM_FRAC; a constant table, no runtime division.
    function automatic logic [NORM_FRAC-1:0] lut_entry(input int k);
        longint num;
        num = longint'(k) << NORM_FRAC;
        return NORM_FRAC'(num / longint'(k + 2));
    endfunction

    logic [NORM_FRAC-1:0] norm_lut [N_CHANNELS+1];

    for (genvar k = 0; k <= N_CHANNELS; k++) begin : g_lut
        assign norm_lut[k] = lut_entry(k);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_strobe) state_next = ACCUM;
            ACCUM:   if (idx == IDX_W'(N_CHANNELS - 1)) state_next = SCALE;
            SCALE:   state_next = NORM;
            NORM:    state_next = SAT;
            SAT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic signed [ACC_W-1:0] wave_ext, gain_ext, term, acc_sh;
    logic signed [S_W-1:0]   acc_sx, mv_sx, s_next;
    logic signed [Y_W-1:0]   s_sx, lut_sx, y_next;
    logic [Y_W-WIDTH:0]      y_upper;
    logic                    fits;
    logic signed [WIDTH-1:0] sat_val;

    // Gains are unsigned, so they are zero-extended before the signed multiply.
    always_comb begin
        wave_ext = {{(ACC_W-WIDTH){wave_q[idx][WIDTH-1]}}, wave_q[idx]};
        gain_ext = {{(ACC_W-GAIN_WIDTH){1'b0}}, gain_q[idx]};
        term     = wave_ext * gain_ext;
        acc_sh   = acc >>> (GAIN_WIDTH - 1);
        acc_sx   = {{(S_W-ACC_W){acc_sh[ACC_W-1]}}, acc_sh};
        mv_sx    = {{(S_W-32){mv_q[31]}}, mv_q};
        s_next   = (acc_sx * mv_sx) >>> VOL_FRAC;
        s_sx     = {{(Y_W-S_W){s_q[S_W-1]}}, s_q};
        lut_sx   = {{(Y_W-NORM_FRAC){1'b0}}, norm_lut[n_q]};
        y_next   = (s_sx * lut_sx) >>> NORM_FRAC;
        y_upper  = y_q[Y_W-1:WIDTH-1];
        fits     = (&y_upper) | ~(|y_upper);
        if (fits)             sat_val = y_q[WIDTH-1:0];
        else if (y_q[Y_W-1])  sat_val = {1'b1, {(WIDTH-1){1'b0}}};
        else                  sat_val = {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                wave_q[i] <= '0;
                gain_q[i] <= '0;
            end
            en_q      <= '0;
            mv_q      <= '0;
            acc       <= '0;
            n_q       <= '0;
            idx       <= '0;
            s_q       <= '0;
            y_q       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            clip      <= 1'b0;
            // A strobe arriving in any non-idle state, the SAT edge included, is dropped.
            if (sample_strobe && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (sample_strobe) begin
                        for (int i = 0; i < N_CHANNELS; i++) begin
                            wave_q[i] <= waves[i];
                            gain_q[i] <= gains[i];
                        end
                        en_q <= enable;
                        mv_q <= master_volume;
                        acc  <= '0;
                        n_q  <= '0;
                        idx  <= '0;
                    end
                end
                ACCUM: begin
                    if (en_q[idx]) begin
                        acc <= acc + term;
                        n_q <= n_q + CNT_W'(1);
                    end
                    idx <= idx + IDX_W'(1);
                end
                SCALE: s_q <= s_next;
                NORM:  y_q <= y_next;
                SAT: begin
                    out       <= sat_val;
                    clip      <= ~fits;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer_seq.sv
// Bench for voice_mixer_seq: directed scenarios plus randomized mixes against an integer model.
module tb_voice_mixer_seq;

    localparam int WIDTH = 24;
    localparam int NCH   = 4;
    localparam int GW    = 16;
    localparam int VF    = 16;
    localparam int NF    = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    sample_strobe;
    logic signed [WIDTH-1:0] waves [NCH];
    logic        [GW-1:0]    gains [NCH];
    logic        [NCH-1:0]   enable;
    logic signed [31:0]      master_volume;
    logic signed [WIDTH-1:0] out;
    logic                    out_valid;
    logic                    busy;
    logic                    clip;
    logic                    overrun;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH:0] exp_q[$];

    voice_mixer_seq #(
        .WIDTH(WIDTH), .N_CHANNELS(NCH), .GAIN_WIDTH(GW), .VOL_FRAC(VF), .NORM_FRAC(NF)
    ) dut (
        .clk(clk), .rst(rst), .sample_strobe(sample_strobe), .waves(waves), .gains(gains),
        .enable(enable), .master_volume(master_volume), .out(out), .out_valid(out_valid),
        .busy(busy), .clip(clip), .overrun(overrun)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Returns {clip, out} for the inputs currently applied.
    function automatic logic [WIDTH:0] model_mix();
        longint acc, s, y, lut, maxv, minv;
        int n;
        logic [63:0] yb;
        acc = 0;
        n   = 0;
        for (int i = 0; i < NCH; i++) begin
            if (enable[i]) begin
                acc += longint'(waves[i]) * longint'({1'b0, gains[i]});
                n++;
            end
        end
        s    = ((acc >>> (GW - 1)) * longint'(master_volume)) >>> VF;
        lut  = (longint'(n) * (longint'(1) << NF)) / longint'(n + 2);
        y    = (s * lut) >>> NF;
        maxv = (longint'(1) << (WIDTH - 1)) - 1;
        minv = -(longint'(1) << (WIDTH - 1));
        if (y > maxv)      y = maxv;
        else if (y < minv) y = minv;
        else begin
            yb = y;
            return {1'b0, yb[WIDTH-1:0]};
        end
        yb = y;
        return {1'b1, yb[WIDTH-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input int w0, input int w1, input int w2, input int w3,
                              input int g0, input int g1, input int g2, input int g3,
                              input logic [NCH-1:0] en, input int mv);
        waves[0] = WIDTH'(w0); waves[1] = WIDTH'(w1);
        waves[2] = WIDTH'(w2); waves[3] = WIDTH'(w3);
        gains[0] = GW'(g0); gains[1] = GW'(g1);
        gains[2] = GW'(g2); gains[3] = GW'(g3);
        enable = en;
        master_volume = mv;
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < NCH; i++) begin
            waves[i] = WIDTH'($urandom);
            gains[i] = GW'($urandom);
        end
        enable = NCH'($urandom);
        master_volume = $urandom;
    endtask

    // Issues one strobe and waits (bounded) for the result; lat counts edges after the accepting edge.
    task automatic run_sample(input bit scramble, output int lat,
                              output logic signed [WIDTH-1:0] o, output logic c, output bit busy_ok);
        @(negedge clk);
        sample_strobe = 1'b1;
        @(posedge clk);
        #1;
        sample_strobe = 1'b0;
        if (scramble) scramble_inputs();
        busy_ok = busy;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid && !busy) busy_ok = 1'b0;
        end
        o = out;
        c = clip;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks += 5;
        if (out !== '0)       begin failures++; $display("FAIL reset_out: got %0d expected 0", out); end
        if (out_valid !== 0)  begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        if (busy !== 0)       begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (clip !== 0)       begin failures++; $display("FAIL reset_clip: got %b expected 0", clip); end
        if (overrun !== 0)    begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_channel();
        int lat; logic signed [WIDTH-1:0] o; logic c; bit bok;
        set_inputs(1000, 0, 0, 0, 32768, 0, 0, 0, 4'b0001, 65536);
        run_sample(0, lat, o, c, bok);
        checks += 4;
        if (o !== 24'sd333) begin failures++; $display("FAIL single_out: got %0d expected 333", o); end
        if (lat != 7)       begin failures++; $display("FAIL single_latency: got %0d expected 7", lat); end
        if (!bok)           begin failures++; $display("FAIL single_busy: busy dropped early"); end
        if (c !== 1'b0)     begin failures++; $display("FAIL single_clip: got %b expected 0", c); end
        @(posedge clk);
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL single_pulse: out_valid got %b expected 0", out_valid); end
        if (out !== 24'sd333)   begin failures++; $display("FAIL single_hold: got %0d expected 333", out); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL single_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_mix_gain();
        int lat; logic signed [WIDTH-1:0] o; logic c; bit bok;
        set_inputs(1000, -200, 0, 0, 32768, 16384, 0, 0, 4'b0011, 65536);
        run_sample(0, lat, o, c, bok);
        checks += 2;
        if (o !== 24'sd450) begin failures++; $display("FAIL mix_out: got %0d expected 450", o); end
        if (c !== 1'b0)     begin failures++; $display("FAIL mix_clip: got %b expected 0", c); end
    endtask

    task automatic test_mask();
        int lat; logic signed [WIDTH-1:0] o; logic c; bit bok;
        set_inputs(1000, 5000, 0, 0, 32768, 16384, 0, 0, 4'b0001, 65536);
        run_sample(0, lat, o, c, bok);
        checks += 1;
        if (o !== 24'sd333) begin failures++; $display("FAIL mask_out: got %0d expected 333", o); end
        enable = 4'b0000;
        run_sample(0, lat, o, c, bok);
        checks += 3;
        if (o !== 24'sd0) begin failures++; $display("FAIL n0_out: got %0d expected 0", o); end
        if (lat != 7)     begin failures++; $display("FAIL n0_valid: latency %0d expected 7", lat); end
        if (c !== 1'b0)   begin failures++; $display("FAIL n0_clip: got %b expected 0", c); end
    endtask

    task automatic test_saturation();
        int lat; logic signed [WIDTH-1:0] o; logic c; bit bok;
        set_inputs(4000000, 4000000, 4000000, 4000000, 32768, 32768, 32768, 32768, 4'b1111, 16 * 65536);
        run_sample(0, lat, o, c, bok);
        checks += 2;
        if (o !== 24'sd8388607) begin failures++; $display("FAIL sat_pos_out: got %0d expected 8388607", o); end
        if (c !== 1'b1)         begin failures++; $display("FAIL sat_pos_clip: got %b expected 1", c); end
        @(posedge clk);
        #1;
        checks += 1;
        if (clip !== 1'b0) begin failures++; $display("FAIL sat_clip_pulse: got %b expected 0", clip); end
        set_inputs(-4000000, -4000000, -4000000, -4000000, 32768, 32768, 32768, 32768, 4'b1111, 16 * 65536);
        run_sample(0, lat, o, c, bok);
        checks += 2;
        if (o !== -24'sd8388608) begin failures++; $display("FAIL sat_neg_out: got %0d expected -8388608", o); end
        if (c !== 1'b1)          begin failures++; $display("FAIL sat_neg_clip: got %b expected 1", c); end
    endtask

    task automatic test_overrun();
        int n_valid;
        int valid_cyc [$];
        logic [WIDTH:0] got, exp;
        n_valid = 0;
        @(negedge clk);
        for (int cyc = 0; cyc <= 17; cyc++) begin
            sample_strobe = (cyc == 0 || cyc == 2 || cyc == 8);
            if (cyc == 0) begin
                set_inputs(1000, 0, 0, 0, 32768, 0, 0, 0, 4'b0001, 65536);
                exp_q.push_back(model_mix());
            end
            if (cyc == 2) set_inputs(4000000, 4000000, 4000000, 4000000, 32768, 32768, 32768, 32768, 4'b1111, 16 * 65536);
            if (cyc == 8) begin
                set_inputs(1000, -200, 0, 0, 32768, 16384, 0, 0, 4'b0011, 65536);
                exp_q.push_back(model_mix());
            end
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                checks++;
                if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_early: got %b expected 0", overrun); end
            end
            if (cyc == 2) begin
                checks++;
                if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: got %b expected 1", overrun); end
            end
            if (out_valid) begin
                n_valid++;
                valid_cyc.push_back(cyc);
                got = {clip, out};
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL overrun_value: cycle %0d got out=%0d clip=%b expected out=%0d clip=%b",
                             cyc, $signed(got[WIDTH-1:0]), got[WIDTH], $signed(exp[WIDTH-1:0]), exp[WIDTH]);
                end
            end
            @(negedge clk);
        end
        sample_strobe = 1'b0;
        checks += 3;
        if (n_valid != 2) begin failures++; $display("FAIL overrun_count: got %0d pulses expected 2", n_valid); end
        else if (valid_cyc[0] != 7 || valid_cyc[1] != 15) begin
            failures++;
            $display("FAIL overrun_timing: got cycles %0d,%0d expected 7,15", valid_cyc[0], valid_cyc[1]);
        end
        if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int seen;
        set_inputs(1000, 0, 0, 0, 32768, 0, 0, 0, 4'b0001, 65536);
        @(negedge clk);
        sample_strobe = 1'b1;
        @(posedge clk);
        #1;
        sample_strobe = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks += 4;
        if (out !== '0)      begin failures++; $display("FAIL rstmid_out: got %0d expected 0", out); end
        if (out_valid !== 0) begin failures++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        if (busy !== 0)      begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        if (overrun !== 0)   begin failures++; $display("FAIL rstmid_overrun: got %b expected 0", overrun); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL rstmid_no_valid: got %0d pulses expected 0", seen); end
    endtask

    task automatic test_random();
        int lat; logic signed [WIDTH-1:0] o; logic c; bit bok;
        logic [WIDTH:0] exp;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < NCH; i++) begin
                waves[i] = WIDTH'($urandom);
                gains[i] = GW'($urandom);
            end
            enable = NCH'($urandom);
            master_volume = int'($urandom_range(0, 8 * 65536)) - 4 * 65536;
            exp_q.push_back(model_mix());
            run_sample(1, lat, o, c, bok);
            exp = exp_q.pop_front();
            checks += 2;
            if ({c, o} !== exp) begin
                failures++;
                $display("FAIL random_%0d: got out=%0d clip=%b expected out=%0d clip=%b",
                         it, o, c, $signed(exp[WIDTH-1:0]), exp[WIDTH]);
            end
            if (lat != 7) begin failures++; $display("FAIL random_latency_%0d: got %0d expected 7", it, lat); end
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic signed [WIDTH-1:0] o; logic c; bit bok;
        logic [WIDTH:0] exp;
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < NCH; i++) begin
                waves[i] = WIDTH'($urandom_range(0, 2000000)) - WIDTH'(1000000);
                gains[i] = GW'($urandom);
            end
            enable = NCH'($urandom);
            master_volume = int'($urandom_range(0, 2 * 65536));
            exp_q.push_back(model_mix());
            run_sample(0, lat, o, c, bok);
            exp = exp_q.pop_front();
            checks++;
            if ({c, o} !== exp) begin
                failures++;
                $display("FAIL b2b_%0d: got out=%0d clip=%b expected out=%0d clip=%b",
                         it, o, c, $signed(exp[WIDTH-1:0]), exp[WIDTH]);
            end
        end
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        sample_strobe = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_channel();
        test_mix_gain();
        test_mask();
        test_saturation();
        test_overrun();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
